// File: rtl/rot_arb_ctrl_pkg.sv
// rtl/rot_arb_ctrl_pkg.sv - shared encodings and defaults for the rotate arbiter/sequencer
package rot_arb_ctrl_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ROT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rot_arb_ctrl_rr_arb2.sv
// rtl/rot_arb_ctrl_rr_arb2.sv - two-way round-robin arbiter with last-winner memory
module rr_arb2
  import rot_arb_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic win_valid,
  output logic win_id
);

  logic last_id;

  // Winner select: a lone requester wins, on a tie the one that did not win last time
  always_comb begin
    win_valid = req_a | req_b;
    win_id    = ID_A;
    if (req_a && req_b) begin
      win_id = ~last_id;
    end else if (req_b) begin
      win_id = ID_B;
    end
  end

  // Remember the most recent winner; reset favours A on the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= ID_B;
    end else if (take && win_valid) begin
      last_id <= win_id;
    end
  end

endmodule

// File: rtl/rot_arb_ctrl.sv
// rtl/rot_arb_ctrl.sv - arbitrates two requesters and sequences the mux/register/rotator datapath
module rot_arb_ctrl
  import rot_arb_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic             dir_a,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic             req_b,
  input  logic             dir_b,
  input  logic [CNT_W-1:0] cnt_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             r_l,
  output logic             ld,
  output logic             rot_en,
  input  logic [WIDTH-1:0] rot_q,
  output logic [WIDTH-1:0] res,
  output logic             res_valid,
  output logic             res_id,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] rem;
  logic             win_valid;
  logic             win_id;
  logic             arb_take;

  // Arbitration only happens in IDLE, so the winner memory advances once per operation
  assign arb_take = (state == ST_IDLE);

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_a     (req_a),
    .req_b     (req_b),
    .take      (arb_take),
    .win_valid (win_valid),
    .win_id    (win_id)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobes decoded from state; sel doubles as the owner id of the operation
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    rot_en    = 1'b0;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ld    = 1'b1;
        gnt_a = (sel == ID_A);
        gnt_b = (sel == ID_B);
        state_nxt = (rem == '0) ? ST_DONE : ST_ROT;
      end
      ST_ROT: begin
        rot_en = 1'b1;
        if (rem <= CNT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operation fields latched at the arbitration edge, rotate countdown and result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sel       <= 1'b0;
      r_l       <= 1'b0;
      rem       <= '0;
      res       <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            sel <= win_id;
            r_l <= (win_id == ID_B) ? dir_b : dir_a;
            rem <= (win_id == ID_B) ? cnt_b : cnt_a;
          end
        end
        ST_ROT: begin
          rem <= rem - 1'b1;
        end
        ST_DONE: begin
          res       <= rot_q;
          res_id    <= sel;
          res_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/rot_arb_ctrl.md
Name: rot_arb_ctrl

Overview:
Arbiter and sequencer for the shared 8-bit mux -> register -> rotator datapath. Two requesters (A, B) each ask for one "load source, rotate N steps in direction D" operation. The controller grants round-robin and drives the mux select, register load, rotate enable and direction for the required number of cycles. It then captures the rotator output as a tagged result.

Parameters:
WIDTH, 8, datapath width (width of rot_q and res)
CNT_W, 3, width of rotate-count fields; max count 2^CNT_W-1

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
req_a  in  1  requester A request, level, held until gnt_a
dir_a  in  1  A direction, 1=left, 0=right
cnt_a  in  CNT_W  A rotate count
req_b  in  1  requester B request
dir_b  in  1  B direction
cnt_b  in  CNT_W  B rotate count
gnt_a  out  1  one-cycle grant pulse to A
gnt_b  out  1  one-cycle grant pulse to B
sel  out  1  mux select to datapath, 0=a_vec, 1=b_vec
r_l  out  1  rotate direction to datapath, 1=left
ld  out  1  datapath register/rotator load strobe
rot_en  out  1  rotator one-step enable
rot_q  in  WIDTH  rotator output from datapath
res  out  WIDTH  captured result
res_valid  out  1  one-cycle result strobe
res_id  out  1  owner of res, 0=A, 1=B
busy  out  1  high in any state other than IDLE

Behaviour:
- Datapath contract: when ld=1, the datapath captures the mux output into register/rotator at the clock edge. When rot_en=1, the rotator rotates one bit per edge in direction r_l. rot_q is valid the cycle after the edge.
- FSM states: IDLE, LOAD, ROT, DONE.
  - IDLE: if req_a or req_b, arbitrate at the edge. Register winner id, dir and cnt into rem. Set sel=id and r_l=dir. Go to LOAD.
  - LOAD (1 cycle): ld=1; gnt_<id>=1. If rem==0, go to DONE; else go to ROT.
  - ROT: rot_en=1; rem decrements each cycle. When rem==1, go to DONE. ROT lasts exactly cnt cycles.
  - DONE (1 cycle): res<=rot_q, res_id<=id, res_valid<=1 (visible the next cycle). Go to IDLE.
- Latency: request sampled at edge E0 -> LOAD in cycle 1 -> ROT in cycles 2..cnt+1 -> DONE in cycle cnt+2 -> res_valid in cycle cnt+3. Back-to-back: a new request sampled in the IDLE cycle coincident with res_valid is accepted.
- Arbitration: round-robin via a last_id register, updated at each grant.
  - Single requester wins outright.
  - If both request, the one not equal to last_id wins.
  - Reset value of last_id=1, so A wins the first tie.
- Requester fields (dir, cnt) are sampled only at the arbitration edge. Changes during an operation are ignored.
- A request still held after its grant is treated as a new request.
- sel and r_l are registered and hold their last values outside operations.
- ld, rot_en, gnt_a, gnt_b and busy are decoded from state.
- cnt=0: load only, pass-through result. cnt>=WIDTH is legal, and the rotation wraps naturally.
- Reset (any state, including mid-ROT): state=IDLE, rem=0, last_id=1. All outputs 0 (sel, r_l, ld, rot_en, gnt_*, res, res_valid, res_id, busy). The in-flight operation is dropped with no res_valid.
- Requests asserted during reset are evaluated at the first IDLE cycle after reset deasserts.

Decomposition:
- Shared header: state encodings (IDLE=0, LOAD=1, ROT=2, DONE=3), ID_A=0/ID_B=1, default WIDTH/CNT_W.
- Sub-module rr_arb2: 2-way round-robin arbiter with last_id register and grant/id outputs.
- rot_arb_ctrl instantiates rr_arb2 plus the FSM, count register and result capture.

Test Plan:
- a_vec=0x81, req_a, dir_a=1, cnt_a=1 -> gnt_a in cycle 1, rot_en exactly 1 cycle, res=0x03, res_id=0, res_valid in cycle 4.
- b_vec=0x81, req_b, dir_b=0, cnt_b=1 -> sel=1, res=0xC0, res_id=1.
- a_vec=0x0F, dir_a=1, cnt_a=0 -> no rot_en, res=0x0F, res_valid in cycle 3.
- req_a and req_b both held, cnt=2 each, a=0x01 left, b=0x80 right:
  - Operations serviced A, B, A, B.
  - Results 0x04 (id 0) and 0x20 (id 1).
  - busy drops only for the single IDLE cycle between operations.
- req_a with cnt_a=7; assert rst in the 3rd ROT cycle -> next cycle all outputs 0, no res_valid.
  - After rst deasserts, a simultaneous req_a and req_b grants A first (last_id reset to 1).
- b_vec=0xA5, dir_b=1, cnt_b=7 -> res=0xD2 (rotate left by 7 equals rotate right by 1).
  - Change cnt_b to 1 mid-operation -> ROT still lasts 7 cycles.
